// File: rtl/hf_decoder_param_if.sv
// Bundle of the table-load port, bit-in stream and symbol-out stream of
// hf_decoder_param. When HF_SYMCOUNT_EN is defined, the bundle also carries
// the 32-bit symbol counter. "master" is the producer/sink side and "slave"
// is the decoder side.
interface hf_decoder_param_if #(
    parameter int SYM_W   = 4,
    parameter int NUM_SYM = 16,
    parameter int MAX_LEN = 8
);
    localparam int IDX_W = $clog2(NUM_SYM);
    localparam int LEN_W = $clog2(MAX_LEN + 1);

    logic             tbl_start;
    logic             tbl_wr;
    logic [IDX_W-1:0] tbl_idx;
    logic [MAX_LEN-1:0] tbl_code;
    logic [LEN_W-1:0] tbl_len;
    logic [SYM_W-1:0] tbl_sym;
    logic             tbl_done;
    logic             hf_in;
    logic             hf_in_valid;
    logic             hf_in_ready;
    logic [SYM_W-1:0] hf_out;
    logic             hf_out_valid;
    logic             hf_out_ready;
    logic             hf_err;
    logic             decoding;
`ifdef HF_SYMCOUNT_EN
    logic [31:0]      sym_count;
`endif

    modport master (
        output tbl_start, tbl_wr, tbl_idx, tbl_code, tbl_len, tbl_sym, tbl_done,
        output hf_in, hf_in_valid, hf_out_ready,
        input  hf_in_ready, hf_out, hf_out_valid, hf_err, decoding
`ifdef HF_SYMCOUNT_EN
        , input sym_count
`endif
    );

    modport slave (
        input  tbl_start, tbl_wr, tbl_idx, tbl_code, tbl_len, tbl_sym, tbl_done,
        input  hf_in, hf_in_valid, hf_out_ready,
        output hf_in_ready, hf_out, hf_out_valid, hf_err, decoding
`ifdef HF_SYMCOUNT_EN
        , output sym_count
`endif
    );
endinterface

// File: rtl/hf_decoder_param.sv
// Bit-serial Huffman decoder with a loadable code table.
// LOAD phase fills {code, len, sym} entries; DECODE phase shifts one bit per
// accepted cycle into a partial code and emits the lowest-index table entry
// whose code and length both match. Tracking the length keeps codes with
// leading zeros from aliasing shorter codes.
// Optional macro HF_SYMCOUNT_EN adds a 32-bit count of delivered symbols.
module hf_decoder_param #(
    parameter int SYM_W   = 4,
    parameter int NUM_SYM = 16,
    parameter int MAX_LEN = 8
) (
    input logic CLK,
    input logic Reset,
    hf_decoder_param_if.slave bus
);
    localparam int LEN_W = $clog2(MAX_LEN + 1);
    localparam int CW    = MAX_LEN + 1;

    typedef enum logic {S_LOAD, S_DECODE} state_t;

    state_t state, state_next;

    // Code table: valid bits are reset, payload is not.
    logic [NUM_SYM-1:0] tbl_vld_q;
    logic [MAX_LEN-1:0] tbl_code_q [NUM_SYM];
    logic [LEN_W-1:0]   tbl_len_q  [NUM_SYM];
    logic [SYM_W-1:0]   tbl_sym_q  [NUM_SYM];

    // Partial code: at most MAX_LEN-1 bits are ever held between bits.
    logic [MAX_LEN-2:0] code_q;
    logic [LEN_W-1:0]   len_q;
    logic [SYM_W-1:0]   out_q;
    logic               out_valid_q;
    logic               err_q;

    logic               tbl_we;
    logic               accept;
    logic [MAX_LEN-1:0] cand;
    logic [LEN_W-1:0]   cand_len;
    logic [CW-1:0]      one_hot;
    logic [CW-1:0]      mask_full;
    logic [MAX_LEN-1:0] cand_mask;
    logic               hit;
    logic [SYM_W-1:0]   hit_sym;

    assign bus.decoding     = (state == S_DECODE);
    assign bus.hf_in_ready  = bus.decoding && !(out_valid_q && !bus.hf_out_ready);
    assign bus.hf_out       = out_q;
    assign bus.hf_out_valid = out_valid_q;
    assign bus.hf_err       = err_q;

    assign accept   = bus.hf_in_valid && bus.hf_in_ready;
    assign tbl_we   = (state == S_LOAD) && bus.tbl_wr && !bus.tbl_start;
    assign cand     = {code_q, bus.hf_in};
    assign cand_len = len_q + LEN_W'(1);

    // State register.
    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge CLK or negedge Reset) begin
        if (!Reset) state <= S_LOAD;
        else        state <= state_next;
    end

    // Next-state: tbl_start always wins; tbl_done only counts in LOAD.
    always_comb begin
        state_next = state;
        if (bus.tbl_start)                            state_next = S_LOAD;
        else if (state == S_LOAD && bus.tbl_done)     state_next = S_DECODE;
    end

    // Entry valid bits: cleared on reset and tbl_start, set by in-range writes.
    always_ff @(posedge CLK or negedge Reset) begin
        if (!Reset) begin
            tbl_vld_q <= '0;
        end else if (bus.tbl_start) begin
            tbl_vld_q <= '0;
        end else if (tbl_we) begin
            tbl_vld_q[bus.tbl_idx] <= (bus.tbl_len != '0) && (bus.tbl_len <= LEN_W'(MAX_LEN));
        end
    end

    // Entry payload, qualified by the valid bit above.
    // NOTE: table storage has no reset; the valid bits alone make stale payload harmless.
    always_ff @(posedge CLK) begin
        if (tbl_we) begin
            tbl_code_q[bus.tbl_idx] <= bus.tbl_code;
            tbl_len_q[bus.tbl_idx]  <= bus.tbl_len;
            tbl_sym_q[bus.tbl_idx]  <= bus.tbl_sym;
        end
    end

    // Match search over the table; scanning downward lets the lowest index win.
    // NOTE: every always_comb output gets a default first so no latch is inferred.
    always_comb begin
        hit       = 1'b0;
        hit_sym   = '0;
        one_hot   = CW'(1) << cand_len;
        mask_full = one_hot - CW'(1);
        cand_mask = mask_full[MAX_LEN-1:0];
        for (int i = NUM_SYM - 1; i >= 0; i--) begin
            if (tbl_vld_q[i] && (tbl_len_q[i] == cand_len) &&
                (((tbl_code_q[i] ^ cand) & cand_mask) == '0)) begin
                hit     = 1'b1;
                hit_sym = tbl_sym_q[i];
            end
        end
    end

    // Decode datapath: partial code shift, symbol output register, error pulse.
    always_ff @(posedge CLK or negedge Reset) begin
        if (!Reset) begin
            code_q      <= '0;
            len_q       <= '0;
            out_q       <= '0;
            out_valid_q <= 1'b0;
            err_q       <= 1'b0;
        end else begin
            err_q <= 1'b0;
            if (bus.tbl_start) begin
                code_q      <= '0;
                len_q       <= '0;
                out_valid_q <= 1'b0;
            end else if (state == S_DECODE) begin
                if (out_valid_q && bus.hf_out_ready) out_valid_q <= 1'b0;
                if (accept) begin
                    if (hit) begin
                        out_q       <= hit_sym;
                        out_valid_q <= 1'b1;
                        code_q      <= '0;
                        len_q       <= '0;
                    end else if (cand_len == LEN_W'(MAX_LEN)) begin
                        err_q  <= 1'b1;
                        code_q <= '0;
                        len_q  <= '0;
                    end else begin
                        code_q <= cand[MAX_LEN-2:0];
                        len_q  <= cand_len;
                    end
                end
            end
        end
    end

`ifdef HF_SYMCOUNT_EN
    logic [31:0] sym_count_q;

    // Delivered-symbol counter; wraps naturally at 2**32.
    always_ff @(posedge CLK or negedge Reset) begin
        if (!Reset)                               sym_count_q <= '0;
        else if (bus.tbl_start)                   sym_count_q <= '0;
        else if (out_valid_q && bus.hf_out_ready) sym_count_q <= sym_count_q + 32'd1;
    end

    assign bus.sym_count = sym_count_q;
`else
    // Symbol counter absent in this build.
`endif
endmodule

// File: tb/tb_hf_decoder_param.sv
// Directed self-checking bench for hf_decoder_param: one instance with the
// default MAX_LEN=8 and one with MAX_LEN=4 for the no-match error path.
module tb_hf_decoder_param;
    logic clk = 1'b0;
    logic rst = 1'b1;
    int   n_checks = 0;
    int   n_errors = 0;

    hf_decoder_param_if #(.SYM_W(4), .NUM_SYM(16), .MAX_LEN(8)) b8 ();
    hf_decoder_param_if #(.SYM_W(4), .NUM_SYM(16), .MAX_LEN(4)) b4 ();

    hf_decoder_param #(.SYM_W(4), .NUM_SYM(16), .MAX_LEN(8)) u_dut8 (
        .CLK(clk), .Reset(rst), .bus(b8.slave));
    hf_decoder_param #(.SYM_W(4), .NUM_SYM(16), .MAX_LEN(4)) u_dut4 (
        .CLK(clk), .Reset(rst), .bus(b4.slave));

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic start8();
        b8.tbl_start = 1'b1;
        tick();
        b8.tbl_start = 1'b0;
    endtask

    task automatic load8(input int idx, input int code, input int len, input int sym, input logic done);
        b8.tbl_idx  = 4'(idx);
        b8.tbl_code = 8'(code);
        b8.tbl_len  = 4'(len);
        b8.tbl_sym  = 4'(sym);
        b8.tbl_wr   = 1'b1;
        b8.tbl_done = done;
        tick();
        b8.tbl_wr   = 1'b0;
        b8.tbl_done = 1'b0;
    endtask

    task automatic done8();
        b8.tbl_done = 1'b1;
        tick();
        b8.tbl_done = 1'b0;
    endtask

    // Present one bit for one cycle, then check the registered output.
    task automatic bit8(input logic b, input string tag, input logic ev, input int es);
        b8.hf_in       = b;
        b8.hf_in_valid = 1'b1;
        tick();
        b8.hf_in_valid = 1'b0;
        check({tag, "_valid"}, 32'(b8.hf_out_valid), 32'(ev));
        if (ev) check({tag, "_sym"}, 32'(b8.hf_out), 32'(es));
        check({tag, "_err"}, 32'(b8.hf_err), 32'd0);
    endtask

    // Basic stream: 0 | 10 | 110 | 111 -> 5, 3, C, 9.
    logic bas_bits [9] = '{1'b0, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 1'b1};
    logic bas_ev   [9] = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1};
    int   bas_sym  [9] = '{5, 0, 3, 0, 0, 12, 0, 0, 9};

    task automatic load_basic();
        load8(0, 0, 1, 5, 1'b0);
        load8(1, 2, 2, 3, 1'b0);
        load8(2, 6, 3, 12, 1'b0);
        load8(3, 7, 3, 9, 1'b1);   // write and tbl_done in the same cycle
    endtask

    initial begin
        {b8.tbl_start, b8.tbl_wr, b8.tbl_done, b8.hf_in, b8.hf_in_valid, b8.hf_out_ready} = '0;
        {b4.tbl_start, b4.tbl_wr, b4.tbl_done, b4.hf_in, b4.hf_in_valid, b4.hf_out_ready} = '0;
        b8.tbl_idx = '0; b8.tbl_code = '0; b8.tbl_len = '0; b8.tbl_sym = '0;
        b4.tbl_idx = '0; b4.tbl_code = '0; b4.tbl_len = '0; b4.tbl_sym = '0;

        // Reset state
        #2 rst = 1'b0;
        #2;
        check("rst_out",      32'(b8.hf_out),       32'd0);
        check("rst_valid",    32'(b8.hf_out_valid), 32'd0);
        check("rst_err",      32'(b8.hf_err),       32'd0);
        check("rst_in_ready", 32'(b8.hf_in_ready),  32'd0);
        check("rst_decoding", 32'(b8.decoding),     32'd0);
        check("rst4_decoding", 32'(b4.decoding),    32'd0);
        tick();
        rst = 1'b1;
        tick();

        // Basic decode
        start8();
        load_basic();
        check("bas_decoding", 32'(b8.decoding),    32'd1);
        check("bas_in_ready", 32'(b8.hf_in_ready), 32'd1);
        b8.hf_out_ready = 1'b1;
        for (int i = 0; i < 9; i++) bit8(bas_bits[i], $sformatf("bas%0d", i), bas_ev[i], bas_sym[i]);

        // Async reset mid-code after bits 1,1
        bit8(1'b1, "mid1", 1'b0, 0);
`ifdef HF_SYMCOUNT_EN
        check("cnt_basic", b8.sym_count, 32'd4);
`endif
        bit8(1'b1, "mid2", 1'b0, 0);
        #2 rst = 1'b0;
        #1;
        check("arst_out",      32'(b8.hf_out),       32'd0);
        check("arst_valid",    32'(b8.hf_out_valid), 32'd0);
        check("arst_in_ready", 32'(b8.hf_in_ready),  32'd0);
        check("arst_decoding", 32'(b8.decoding),     32'd0);
        @(posedge clk);
        #1 rst = 1'b1;
        load_basic();
        bit8(1'b1, "clean0", 1'b0, 0);
        bit8(1'b1, "clean1", 1'b0, 0);
        bit8(1'b0, "clean2", 1'b1, 12);

        // Reload with a partial code pending
        bit8(1'b1, "pend", 1'b0, 0);
        start8();
        check("rl_decoding", 32'(b8.decoding),     32'd0);
        check("rl_valid",    32'(b8.hf_out_valid), 32'd0);
        check("rl_in_ready", 32'(b8.hf_in_ready),  32'd0);
`ifdef HF_SYMCOUNT_EN
        check("cnt_reload", b8.sym_count, 32'd0);
`endif
        load8(0, 0, 0, 15, 1'b0);  // len 0: invalid
        load8(1, 0, 9, 13, 1'b0);  // len > MAX_LEN: invalid
        load8(2, 0, 1, 7, 1'b0);
        load8(5, 0, 1, 14, 1'b0);  // also matches "0", loses to index 2
        load8(6, 1, 1, 2, 1'b0);
        done8();
        load8(0, 0, 1, 15, 1'b0);  // ignored in DECODE
        bit8(1'b1, "rl_a", 1'b1, 2);
        bit8(1'b0, "rl_b", 1'b1, 7);

        // Leading zeros: {1 -> A, 01 -> 6}
        start8();
        load8(0, 1, 1, 10, 1'b0);
        load8(1, 1, 2, 6, 1'b1);
        bit8(1'b0, "lz0", 1'b0, 0);
        bit8(1'b1, "lz1", 1'b1, 6);

        // Consumed output replaced by a new match with no bubble
        bit8(1'b1, "nobubble", 1'b1, 10);

        // Backpressure
        b8.hf_out_ready = 1'b0;
        #1;
        check("bp_in_ready", 32'(b8.hf_in_ready), 32'd0);
        b8.hf_in       = 1'b0;
        b8.hf_in_valid = 1'b1;
        for (int i = 0; i < 3; i++) begin
            tick();
            check($sformatf("bp_hold_valid%0d", i), 32'(b8.hf_out_valid), 32'd1);
            check($sformatf("bp_hold_sym%0d", i),   32'(b8.hf_out),       32'd10);
            check($sformatf("bp_hold_rdy%0d", i),   32'(b8.hf_in_ready),  32'd0);
        end
        b8.hf_out_ready = 1'b1;
        #1;
        check("bp_release_rdy", 32'(b8.hf_in_ready), 32'd1);
        tick();
        b8.hf_in_valid = 1'b0;
        check("bp_release_valid", 32'(b8.hf_out_valid), 32'd0);
        bit8(1'b1, "bp_resume", 1'b1, 6);

        // No match at MAX_LEN=4: table {0 -> 1}, stream 1,1,1,1 then 0
        b4.tbl_idx  = 4'd0;
        b4.tbl_code = 4'd0;
        b4.tbl_len  = 3'd1;
        b4.tbl_sym  = 4'd1;
        b4.tbl_wr   = 1'b1;
        tick();
        b4.tbl_wr   = 1'b0;
        b4.tbl_done = 1'b1;
        tick();
        b4.tbl_done = 1'b0;
        b4.hf_out_ready = 1'b1;
        b4.hf_in       = 1'b1;
        b4.hf_in_valid = 1'b1;
        for (int i = 0; i < 4; i++) begin
            tick();
            check($sformatf("err_pulse%0d", i), 32'(b4.hf_err),       32'(i == 3));
            check($sformatf("err_valid%0d", i), 32'(b4.hf_out_valid), 32'd0);
        end
        b4.hf_in = 1'b0;
        tick();
        b4.hf_in_valid = 1'b0;
        check("err_after",       32'(b4.hf_err),       32'd0);
        check("err_after_valid", 32'(b4.hf_out_valid), 32'd1);
        check("err_after_sym",   32'(b4.hf_out),       32'd1);
        tick();
        check("err_quiet", 32'(b4.hf_err), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end
endmodule
